// File: rtl/pipe_select_reg.sv
// pipe_select_reg: NUM_IN-way WIDTH-bit operand select feeding a STAGES-deep valid/stall/flush pipeline.
// Define PIPE_SELECT_ERRCNT_EN to build the saturating illegal-select counter behind err_count.
module pipe_select_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN),
  parameter int STAGES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_err,
  output logic [15:0]             err_count
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_err;

  // Codes with no matching input fall through to zero data with the error flag set, never X.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stage_valid <= '0;
      stage_err   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_data[i] <= '0;
      end
    end else if (!stall) begin
      stage_valid[0] <= in_valid;
      stage_err[0]   <= in_valid & sel_err;
      stage_data[0]  <= in_valid ? sel_data : '0;
      for (int i = 1; i < STAGES; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_err[i]   <= stage_err[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign out_data  = stage_data[STAGES-1];
  assign out_valid = stage_valid[STAGES-1];
  assign out_err   = stage_err[STAGES-1];

`ifdef PIPE_SELECT_ERRCNT_EN
  logic        accept;
  logic [15:0] err_cnt_q;

  assign accept = in_valid & ~stall & ~flush;

  // Counted at acceptance, so a later flush does not undo the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (accept && sel_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_select_reg.sv
// Scoreboard bench for pipe_select_reg: three instances (STAGES=1,2,3) share one stimulus stream.
// Expected beats are queued at acceptance and popped when the instance under test emits them.
module tb_pipe_select_reg;

  localparam int W = 32;
  localparam int N = 3;
`ifdef PIPE_SELECT_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N*W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         stall;
  logic         flush;

  logic [W-1:0] d1, d2, d3;
  logic         v1, v2, v3;
  logic         e1, e2, e3;
  logic [15:0]  c1, c2, c3;

  int    total = 0;
  int    bad = 0;
  int    exp_cnt = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  pipe_select_reg #(.WIDTH(W), .NUM_IN(N), .STAGES(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d1), .out_valid(v1), .out_err(e1), .err_count(c1));

  pipe_select_reg #(.WIDTH(W), .NUM_IN(N), .STAGES(2)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d2), .out_valid(v2), .out_err(e2), .err_count(c2));

  pipe_select_reg #(.WIDTH(W), .NUM_IN(N), .STAGES(3)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d3), .out_valid(v3), .out_err(e3), .err_count(c3));

  function automatic beat_t model(input logic [N*W-1:0] din, input logic [1:0] sel);
    beat_t b;
    if (sel < 2'd3) begin
      b.d = din[int'(sel)*W +: W];
      b.e = 1'b0;
    end else begin
      b.d = '0;
      b.e = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [15:0] want_cnt();
    return CNT_EN ? 16'(exp_cnt) : 16'h0000;
  endfunction

  // Record what the coming edge does to the scoreboard, then take the edge.
  task automatic cycle();
    if (reset) begin
      sb.delete();
      exp_cnt = 0;
    end else if (flush) begin
      sb.delete();
    end else if (in_valid && !stall) begin
      sb.push_back(model(in_data, in_sel));
      if (in_sel == 2'd3 && exp_cnt < 65535) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_sel = 2'd0; stall = 1'b0; flush = 1'b0;
    in_data = {32'd33, 32'd22, 32'd11};
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        reset = 1'b0;
        in_valid = 1'b0;
      end
      cycle();
      total++;
      if ({v1, e1, d1, c1} !== '0 || v2 !== 1'b0 || v3 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_%0d: got v=%0b e=%0b d=%0h cnt=%0h v2=%0b v3=%0b want all 0",
                 i, v1, e1, d1, c1, v2, v3);
      end
    end
  endtask

  task automatic test_select_sweep();
    beat_t b;
    in_data = {32'd33, 32'd22, 32'd11};
    for (int s = 0; s < 3; s++) begin
      in_sel = 2'(s);
      in_valid = 1'b1;
      cycle();
      total++;
      if (v1 !== 1'b1 || sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL sweep_valid_%0d: got v=%0b queued=%0d want v=1", s, v1, sb.size());
      end else begin
        b = sb.pop_front();
        if ({d1, e1} !== {b.d, b.e} || d1 !== 32'(11 * (s + 1))) begin
          bad++;
          $display("[TB] FAIL sweep_data_%0d: got d=%0d e=%0b want d=%0d e=%0b", s, d1, e1, b.d, b.e);
        end
      end
    end
  endtask

  task automatic test_illegal();
    beat_t b;
    in_sel = 2'd3;
    in_valid = 1'b1;
    cycle();
    total++;
    b = (sb.size() != 0) ? sb.pop_front() : beat_t'('0);
    if (v1 !== 1'b1 || d1 !== 32'd0 || e1 !== 1'b1 || b.e !== 1'b1) begin
      bad++;
      $display("[TB] FAIL illegal_out: got v=%0b d=%0h e=%0b want v=1 d=0 e=1", v1, d1, e1);
    end
    total++;
    if (c1 !== want_cnt() || c1 !== (CNT_EN ? 16'd1 : 16'd0)) begin
      bad++;
      $display("[TB] FAIL illegal_cnt: got %0d want %0d", c1, want_cnt());
    end
    in_valid = 1'b0;
    cycle();
    total++;
    if ({v1, e1, d1} !== '0) begin
      bad++;
      $display("[TB] FAIL illegal_bubble: got v=%0b e=%0b d=%0h want 0", v1, e1, d1);
    end
  endtask

  task automatic test_stall();
    bit         vt [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    bit         st [10] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    logic [1:0] sl [10] = '{0, 1, 1, 1, 2, 0, 0, 0, 0, 0};
    logic [W-1:0] pd;
    logic pv, pe;
    beat_t b;
    int first = -1;
    int seen = 0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_data = {32'd3, 32'd2, 32'd1};
    for (int e = 0; e < 10; e++) begin
      in_valid = vt[e]; stall = st[e]; in_sel = sl[e];
      pv = v3; pd = d3; pe = e3;
      cycle();
      total++;
      if (st[e]) begin
        if ({v3, e3, d3} !== {pv, pe, pd}) begin
          bad++;
          $display("[TB] FAIL stall_frozen_%0d: got v=%0b d=%0d want v=%0b d=%0d", e, v3, d3, pv, pd);
        end
      end else if (v3) begin
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL stall_dup_%0d: got extra beat d=%0d want none", e, d3);
        end else begin
          b = sb.pop_front();
          seen++;
          if (first < 0) first = e + 1;
          if ({d3, e3} !== {b.d, b.e} || d3 !== 32'(seen)) begin
            bad++;
            $display("[TB] FAIL stall_data_%0d: got d=%0d e=%0b want d=%0d e=%0b", e, d3, e3, b.d, b.e);
          end
        end
      end else if ({e3, d3} !== '0) begin
        bad++;
        $display("[TB] FAIL stall_bubble_%0d: got e=%0b d=%0h want 0", e, e3, d3);
      end
    end
    stall = 1'b0;
    total++;
    if (seen != 3 || sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL stall_count: got %0d beats (%0d left) want 3 (0 left)", seen, sb.size());
    end
    total++;
    if (first != 5) begin
      bad++;
      $display("[TB] FAIL stall_latency: got %0d cycles want 5", first);
    end
  endtask

  task automatic test_flush_stall();
    beat_t b;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_data = {32'd33, 32'd22, 32'd11};
    in_valid = 1'b1;
    in_sel = 2'd0;
    cycle();
    in_sel = 2'd1;
    cycle();
    total++;
    b = (sb.size() != 0) ? sb.pop_front() : beat_t'('0);
    if (v2 !== 1'b1 || d2 !== b.d || d2 !== 32'd11) begin
      bad++;
      $display("[TB] FAIL flush_full: got v=%0b d=%0d want v=1 d=11", v2, d2);
    end
    flush = 1'b1; stall = 1'b1; in_sel = 2'd2;
    cycle();
    total++;
    if ({v2, e2, d2} !== '0) begin
      bad++;
      $display("[TB] FAIL flush_out: got v=%0b e=%0b d=%0d want 0", v2, e2, d2);
    end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if ({v2, e2, d2} !== '0) begin
        bad++;
        $display("[TB] FAIL flush_drop_%0d: got v=%0b d=%0d want 0", i, v2, d2);
      end
    end
    total++;
    if (c2 !== want_cnt()) begin
      bad++;
      $display("[TB] FAIL flush_cnt: got %0d want %0d", c2, want_cnt());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pd;
    logic pv, pe, was_stall;
    beat_t b;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 64; i++) begin
      in_data = {$urandom(), $urandom(), $urandom()};
      in_sel = 2'($urandom_range(0, 3));
      in_valid = (i < 60) && ($urandom_range(0, 3) != 0);
      stall = (i < 60) && ($urandom_range(0, 4) == 0);
      was_stall = stall;
      pv = v3; pd = d3; pe = e3;
      cycle();
      total++;
      if (was_stall) begin
        if ({v3, e3, d3} !== {pv, pe, pd}) begin
          bad++;
          $display("[TB] FAIL b2b_frozen_%0d: got v=%0b d=%0h want v=%0b d=%0h", i, v3, d3, pv, pd);
        end
      end else if (v3) begin
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL b2b_dup_%0d: got extra beat d=%0h want none", i, d3);
        end else begin
          b = sb.pop_front();
          if ({d3, e3} !== {b.d, b.e}) begin
            bad++;
            $display("[TB] FAIL b2b_data_%0d: got d=%0h e=%0b want d=%0h e=%0b", i, d3, e3, b.d, b.e);
          end
        end
      end else if ({e3, d3} !== '0) begin
        bad++;
        $display("[TB] FAIL b2b_bubble_%0d: got e=%0b d=%0h want 0", i, e3, d3);
      end
    end
    stall = 1'b0;
    total++;
    if (sb.size() != 0 || c3 !== want_cnt()) begin
      bad++;
      $display("[TB] FAIL b2b_end: got left=%0d cnt=%0d want left=0 cnt=%0d", sb.size(), c3, want_cnt());
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'd3;
    repeat (CNT_EN ? 65537 : 20) cycle();
    sb.delete();
    total++;
    if (c1 !== want_cnt() || c1 !== (CNT_EN ? 16'hFFFF : 16'h0000) || v1 !== 1'b1 || e1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_cnt: got cnt=%0h v=%0b e=%0b want cnt=%0h v=1 e=1", c1, v1, e1, want_cnt());
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    total++;
    if ({c1, v1, e1, d1} !== '0) begin
      bad++;
      $display("[TB] FAIL sat_reset: got cnt=%0h v=%0b want 0", c1, v1);
    end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_illegal();
    test_stall();
    test_flush_stall();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
